spi_slave: RTL and testbench

SPI responder for the SPI_MASTER link. Runs on the system clock and oversamples SCK/MOSI/SS through 2-FF synchronisers. Shifts one byte in from MOSI while shifting one byte out on MISO, then presents the received byte with a one-cycle newData strobe.
Bus format matches SPI_MASTER:
- SCK idles high; first edge is falling.
- MOSI/MISO change on the falling edge and are sampled on the rising edge.
- MSB first, 8-bit frames.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared encodings and constants for the SPI responder and its synchroniser.
package spi_pkg;

    localparam int DATAWIDTH_BUS = 8;
    localparam logic SCK_IDLE = 1'b1;

    typedef enum logic [1:0] {
        SLV_IDLE  = 2'b00,
        SLV_ARMED = 2'b01,
        SLV_SHIFT = 2'b10,
        SLV_DONE  = 2'b11
    } slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser with a third flop for edge detection; output lags the pin by 2 clocks,
// edge strobes are valid for one clock once the new level reaches the second flop.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic SPI_MASTER_CLOCK_50,
    input  logic SPI_MASTER_RESET_InHigh,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh) begin
        if (SPI_MASTER_RESET_InHigh) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign dout = s2_q;
    assign rise = ~prev_q & s2_q;
    assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder (SCK idle high, MSB first): newData pulses 3-4 clocks after the 8th SCK rise.
// No backpressure; optional SCK-inactivity abort under SPI_SLAVE_IDLE_TIMEOUT_EN.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = spi_pkg::DATAWIDTH_BUS,
    parameter int STATE_SIZE     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     SPI_MASTER_CLOCK_50,
    input  logic                     SPI_MASTER_RESET_InHigh,
    input  logic                     SPI_SLAVE_SCK_In,
    input  logic                     SPI_SLAVE_MOSI_In,
    input  logic                     SPI_SLAVE_SS_InLow,
    input  logic [DATAWIDTH_BUS-1:0] SPI_SLAVE_data_In,
    input  logic                     SPI_SLAVE_load_InHigh,
    output logic                     SPI_SLAVE_MISO_Out,
    output logic [DATAWIDTH_BUS-1:0] SPI_SLAVE_data_Out,
    output logic                     SPI_SLAVE_newData_Out,
    output logic                     SPI_SLAVE_busy_Out
);

    localparam logic [2:0] LAST_BIT = 3'(DATAWIDTH_BUS - 1);

    logic sck_sync_unused, sck_rise, sck_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
    logic ss_sync, ss_rise_unused, ss_fall_unused;

    spi_sync_edge #(.RST_VAL(SCK_IDLE)) u_sync_sck (
        .SPI_MASTER_CLOCK_50     (SPI_MASTER_CLOCK_50),
        .SPI_MASTER_RESET_InHigh (SPI_MASTER_RESET_InHigh),
        .din                     (SPI_SLAVE_SCK_In),
        .dout                    (sck_sync_unused),
        .rise                    (sck_rise),
        .fall                    (sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_mosi (
        .SPI_MASTER_CLOCK_50     (SPI_MASTER_CLOCK_50),
        .SPI_MASTER_RESET_InHigh (SPI_MASTER_RESET_InHigh),
        .din                     (SPI_SLAVE_MOSI_In),
        .dout                    (mosi_sync),
        .rise                    (mosi_rise_unused),
        .fall                    (mosi_fall_unused)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .SPI_MASTER_CLOCK_50     (SPI_MASTER_CLOCK_50),
        .SPI_MASTER_RESET_InHigh (SPI_MASTER_RESET_InHigh),
        .din                     (SPI_SLAVE_SS_InLow),
        .dout                    (ss_sync),
        .rise                    (ss_rise_unused),
        .fall                    (ss_fall_unused)
    );

    slv_state_t                 state_q, state_d;
    logic [DATAWIDTH_BUS-1:0]   txbuf_q, txbuf_d;
    logic [DATAWIDTH_BUS-1:0]   txshift_q, txshift_d;
    logic [DATAWIDTH_BUS-1:0]   rxshift_q, rxshift_d;
    logic [2:0]                 bitcnt_q, bitcnt_d;
    logic                       miso_q, miso_d;
    logic [DATAWIDTH_BUS-1:0]   data_out_q, data_out_d;
    logic                       new_data_q, new_data_d;
    logic                       tmo_hit;

`ifdef SPI_SLAVE_IDLE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (!(sck_rise || sck_fall) &&
            (state_q == SLV_SHIFT || (state_q == SLV_ARMED && bitcnt_q != 3'd0)))
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh) begin
        if (SPI_MASTER_RESET_InHigh) tmo_q <= '0;
        else                         tmo_q <= tmo_d;
    end

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        txbuf_d    = SPI_SLAVE_load_InHigh ? SPI_SLAVE_data_In : txbuf_q;
        txshift_d  = txshift_q;
        rxshift_d  = rxshift_q;
        bitcnt_d   = bitcnt_q;
        miso_d     = miso_q;
        data_out_d = data_out_q;
        new_data_d = 1'b0;

        case (state_q)
            SLV_IDLE: begin
                miso_d = txbuf_q[DATAWIDTH_BUS-1];
                if (!ss_sync) begin
                    state_d   = SLV_ARMED;
                    txshift_d = txbuf_q;
                    bitcnt_d  = 3'd0;
                end
            end
            SLV_ARMED: begin
                if (sck_fall) begin
                    miso_d  = txshift_q[DATAWIDTH_BUS-1];
                    state_d = SLV_SHIFT;
                end
            end
            SLV_SHIFT: begin
                if (sck_rise) begin
                    rxshift_d = {rxshift_q[DATAWIDTH_BUS-2:0], mosi_sync};
                    if (bitcnt_q == LAST_BIT) state_d  = SLV_DONE;
                    else                      bitcnt_d = bitcnt_q + 3'd1;
                end else if (sck_fall) begin
                    txshift_d = txshift_q << 1;
                    miso_d    = txshift_q[DATAWIDTH_BUS-2];
                end
            end
            SLV_DONE: begin
                data_out_d = rxshift_q;
                new_data_d = 1'b1;
                // A load landing this very cycle must reach the next frame.
                txshift_d  = SPI_SLAVE_load_InHigh ? SPI_SLAVE_data_In : txbuf_q;
                bitcnt_d   = 3'd0;
                state_d    = SLV_ARMED;
            end
            default: state_d = SLV_IDLE;
        endcase

        if (ss_sync || tmo_hit) begin
            state_d    = SLV_IDLE;
            bitcnt_d   = 3'd0;
            rxshift_d  = '0;
            data_out_d = data_out_q;
            new_data_d = 1'b0;
        end
    end

    always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh) begin
        if (SPI_MASTER_RESET_InHigh) begin
            state_q    <= SLV_IDLE;
            txbuf_q    <= '1;
            txshift_q  <= '0;
            rxshift_q  <= '0;
            bitcnt_q   <= 3'd0;
            miso_q     <= 1'b1;
            data_out_q <= '0;
            new_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            txbuf_q    <= txbuf_d;
            txshift_q  <= txshift_d;
            rxshift_q  <= rxshift_d;
            bitcnt_q   <= bitcnt_d;
            miso_q     <= miso_d;
            data_out_q <= data_out_d;
            new_data_q <= new_data_d;
        end
    end

    assign SPI_SLAVE_MISO_Out    = miso_q;
    assign SPI_SLAVE_data_Out    = data_out_q;
    assign SPI_SLAVE_newData_Out = new_data_q;
    assign SPI_SLAVE_busy_Out    = (state_q == SLV_SHIFT) || (state_q == SLV_DONE);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural SPI master (8 clocks per SCK half-period) plus newData scoreboard.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sck  = 1'b1;
    logic       mosi = 1'b1;
    logic       ss   = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din  = 8'h00;
    logic       miso;
    logic [7:0] dout;
    logic       nd;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic nd_prev = 1'b0;

    always #10 clk = ~clk;

    spi_slave dut (
        .SPI_MASTER_CLOCK_50     (clk),
        .SPI_MASTER_RESET_InHigh (rst),
        .SPI_SLAVE_SCK_In        (sck),
        .SPI_SLAVE_MOSI_In       (mosi),
        .SPI_SLAVE_SS_InLow      (ss),
        .SPI_SLAVE_data_In       (din),
        .SPI_SLAVE_load_InHigh   (load),
        .SPI_SLAVE_MISO_Out      (miso),
        .SPI_SLAVE_data_Out      (dout),
        .SPI_SLAVE_newData_Out   (nd),
        .SPI_SLAVE_busy_Out      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every newData pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (nd) begin
            check("newdata_single_cycle", {31'b0, nd_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_newdata: got data 0x%0h expected no pulse at %0t", dout, $time);
            end else begin
                check("slave_rx", {24'b0, dout}, {24'b0, exp_q.pop_front()});
            end
        end
        nd_prev = nd;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ld_mode: 0 none, 1 load during the slave's DONE cycle, 2 load mid-frame.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int ld_mode,
                            input logic [7:0] ld_val, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            wait_clks(8);
            sck  = 1'b0;
            mosi = tx[7-i];
            if (ld_mode == 2 && i == 4) begin
                wait_clks(3);
                din = ld_val; load = 1'b1;
                wait_clks(1);
                load = 1'b0;
                wait_clks(4);
            end else begin
                wait_clks(8);
            end
            sck = 1'b1;
            rx[7-i] = miso;
        end
        if (nbits == 8) begin
            if (ld_mode == 1) begin
                // Rise reaches the state register 3 clocks later; DONE is the following cycle.
                wait_clks(3);
                din = ld_val; load = 1'b1;
                wait_clks(1);
                load = 1'b0;
                wait_clks(4);
            end else begin
                wait_clks(8);
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] tx, input logic [7:0] exp_master,
                             input int ld_mode, input logic [7:0] ld_val);
        logic [7:0] rx;
        exp_q.push_back(tx);
        spi_bits(tx, 8, ld_mode, ld_val, rx);
        check("master_rx", {24'b0, rx}, {24'b0, exp_master});
    endtask

    initial begin
        logic [7:0] rx;

        wait_clks(3);
        check("rst_miso", {31'b0, miso}, 32'd1);
        check("rst_data_out", {24'b0, dout}, 32'h00);
        check("rst_newdata", {31'b0, nd}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        wait_clks(2);

        // Preload while deselected so the first frame carries it.
        din = 8'h3C; load = 1'b1;
        wait_clks(1);
        load = 1'b0;
        ss = 1'b0;
        wait_clks(8);

        run_frame(8'hA5, 8'h3C, 0, 8'h00);

        // Back-to-back: old buffer resent, then DONE-cycle bypass load.
        run_frame(8'h01, 8'h3C, 1, 8'h55);
        run_frame(8'h80, 8'h55, 0, 8'h00);
        // Mid-frame load affects only the following frame.
        run_frame(8'h11, 8'h55, 2, 8'h99);
        run_frame(8'h22, 8'h99, 0, 8'h00);

        // SS abort after 4 rising edges.
        spi_bits(8'hE7, 4, 0, 8'h00, rx);
        wait_clks(8);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        ss = 1'b1;
        wait_clks(6);
        check("abort_busy_after", {31'b0, busy}, 32'd0);
        check("abort_data_kept", {24'b0, dout}, 32'h22);
        ss = 1'b0;
        wait_clks(8);
        run_frame(8'hC3, 8'h99, 0, 8'h00);

        // Reset mid-frame at bit 5.
        spi_bits(8'hF0, 5, 0, 8'h00, rx);
        wait_clks(3);
        sck = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_miso", {31'b0, miso}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_data_out", {24'b0, dout}, 32'h00);
        sck = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(10);
        run_frame(8'h7E, 8'hFF, 0, 8'h00);

        // SCK stalls after 3 bits.
        spi_bits(8'h5A, 3, 0, 8'h00, rx);
        wait_clks(100);
`ifdef SPI_SLAVE_IDLE_TIMEOUT_EN
        check("stall_busy", {31'b0, busy}, 32'd0);
`else
        check("stall_busy", {31'b0, busy}, 32'd1);
`endif
        ss = 1'b1;
        wait_clks(6);
        ss = 1'b0;
        wait_clks(8);
        run_frame(8'h96, 8'hFF, 0, 8'h00);

        wait_clks(20);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
